// File: rtl/moore_seq_detector.sv
// Moore recogniser for a runtime-loaded DEPTH-symbol pattern.
// Supports overlapping or non-overlapping matches, an absorbing trap symbol and a saturating match counter.
module moore_seq_detector #(
  parameter int SYM_W = 2,
  parameter int DEPTH = 3,
  parameter int CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [SYM_W-1:0]       in_sym,
  input  logic                   cfg_load,
  input  logic [DEPTH*SYM_W-1:0] cfg_pattern,
  input  logic                   cfg_overlap,
  input  logic                   cfg_trap_en,
  input  logic [SYM_W-1:0]       cfg_trap_sym,
  input  logic                   clear,
  output logic                   o_idle,
  output logic                   o_match,
  output logic                   o_trap,
  output logic [1:0]             state_o,
  output logic [CNT_W-1:0]       match_cnt
);

  localparam int HW = DEPTH * SYM_W;
  localparam int FILL_W = $clog2(DEPTH + 1);
  localparam logic [FILL_W-1:0] FULL = FILL_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ACC  = 2'b01,
    HIT  = 2'b10,
    TRAP = 2'b11
  } state_t;

  state_t            state;
  logic [HW-1:0]     hist;
  logic [HW-1:0]     pattern;
  logic [FILL_W-1:0] fill;
  logic              overlap;
  logic              trap_en;
  logic [SYM_W-1:0]  trap_sym;

  logic              accept;
  logic              is_trap;
  logic              is_match;
  logic [HW-1:0]     hist_next;
  logic [FILL_W-1:0] fill_next;

  // Newest symbol enters at the top slot so slot 0 always holds the oldest, matching the pattern layout.
  assign accept    = in_valid && (state != TRAP);
  assign hist_next = {in_sym, hist[HW-1:SYM_W]};
  assign fill_next = (fill == FULL) ? FULL : fill + FILL_W'(1);
  assign is_trap   = trap_en && (in_sym == trap_sym);
  assign is_match  = (fill_next == FULL) && (hist_next == pattern);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      hist      <= '0;
      fill      <= '0;
      match_cnt <= '0;
      pattern   <= '0;
      overlap   <= 1'b0;
      trap_en   <= 1'b0;
      trap_sym  <= '0;
    end else if (cfg_load) begin
      pattern   <= cfg_pattern;
      overlap   <= cfg_overlap;
      trap_en   <= cfg_trap_en;
      trap_sym  <= cfg_trap_sym;
      state     <= IDLE;
      hist      <= '0;
      fill      <= '0;
      match_cnt <= '0;
    end else if (clear) begin
      state     <= IDLE;
      hist      <= '0;
      fill      <= '0;
      match_cnt <= '0;
    end else if (accept) begin
      hist <= hist_next;
      if (is_trap) begin
        state <= TRAP;
        fill  <= fill_next;
      end else if (is_match) begin
        state <= HIT;
        fill  <= overlap ? FULL : '0;
        if (match_cnt != CNT_MAX) match_cnt <= match_cnt + CNT_W'(1);
      end else begin
        state <= ACC;
        fill  <= fill_next;
      end
    end else if (state == HIT) begin
      state <= (fill == '0) ? IDLE : ACC;
    end
  end

  assign state_o = state;
  assign o_idle  = (state == IDLE);
  assign o_match = (state == HIT);
  assign o_trap  = (state == TRAP);

endmodule

// File: tb/tb_moore_seq_detector.sv
// Bench for moore_seq_detector: directed scenarios plus random traffic,
// all checked every cycle against a queue-based reference model.
module tb_moore_seq_detector;

  localparam int SYM_W = 2;
  localparam int DEPTH = 3;
  localparam int CNT_W = 2;
  localparam int HW = DEPTH * SYM_W;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic [SYM_W-1:0] in_sym;
  logic             cfg_load;
  logic [HW-1:0]    cfg_pattern;
  logic             cfg_overlap;
  logic             cfg_trap_en;
  logic [SYM_W-1:0] cfg_trap_sym;
  logic             clear;
  logic             o_idle;
  logic             o_match;
  logic             o_trap;
  logic [1:0]       state_o;
  logic [CNT_W-1:0] match_cnt;

  int total = 0;
  int bad = 0;
  logic chk_en = 1'b0;

  // Reference model: the accepted symbols since the last flush, how many count toward the next match, and flags.
  logic [SYM_W-1:0] m_q[$];
  int               m_fill;
  int               m_cnt;
  int               m_state;
  logic [HW-1:0]    m_pat;
  logic             m_ov;
  logic             m_te;
  logic [SYM_W-1:0] m_ts;

  moore_seq_detector #(.SYM_W(SYM_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sym(in_sym),
    .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_overlap(cfg_overlap),
    .cfg_trap_en(cfg_trap_en), .cfg_trap_sym(cfg_trap_sym), .clear(clear),
    .o_idle(o_idle), .o_match(o_match), .o_trap(o_trap),
    .state_o(state_o), .match_cnt(match_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_flush();
    m_q.delete();
    m_fill = 0;
    m_state = 0;
    m_cnt = 0;
  endtask

  task automatic model_reset();
    model_flush();
    m_pat = '0;
    m_ov = 1'b0;
    m_te = 1'b0;
    m_ts = '0;
  endtask

  task automatic model_step();
    bit hit;
    if (cfg_load) begin
      m_pat = cfg_pattern;
      m_ov = cfg_overlap;
      m_te = cfg_trap_en;
      m_ts = cfg_trap_sym;
      model_flush();
    end else if (clear) begin
      model_flush();
    end else if (in_valid && m_state != 3) begin
      m_q.push_back(in_sym);
      if (m_q.size() > DEPTH) void'(m_q.pop_front());
      m_fill = (m_fill < DEPTH) ? m_fill + 1 : DEPTH;
      hit = (m_fill == DEPTH);
      for (int k = 0; k < DEPTH; k++)
        if (hit && m_q[k] != m_pat[k*SYM_W +: SYM_W]) hit = 0;
      if (m_te && in_sym == m_ts) begin
        m_state = 3;
      end else if (hit) begin
        m_state = 2;
        if (m_cnt < CNT_MAX) m_cnt++;
        if (!m_ov) m_fill = 0;
      end else begin
        m_state = 1;
      end
    end else if (m_state == 2) begin
      m_state = (m_fill == 0) ? 0 : 1;
    end
  endtask

  task automatic apply_stimulus(input logic v, input logic [SYM_W-1:0] s,
                                input logic ld, input logic clr);
    in_valid = v;
    in_sym = s;
    cfg_load = ld;
    clear = clr;
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic feed(input logic [SYM_W-1:0] s);
    apply_stimulus(1'b1, s, 1'b0, 1'b0);
  endtask

  task automatic load_cfg(input logic [HW-1:0] pat, input logic ov,
                          input logic te, input logic [SYM_W-1:0] ts);
    cfg_pattern = pat;
    cfg_overlap = ov;
    cfg_trap_en = te;
    cfg_trap_sym = ts;
    apply_stimulus(1'b0, '0, 1'b1, 1'b0);
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check_output("state_o", int'(state_o), m_state);
      check_output("o_idle", int'(o_idle), int'(m_state == 0));
      check_output("o_match", int'(o_match), int'(m_state == 2));
      check_output("o_trap", int'(o_trap), int'(m_state == 3));
      check_output("match_cnt", int'(match_cnt), m_cnt);
    end
  end

  initial begin
    int r;
    logic [SYM_W-1:0] s;
    rst = 1'b0;
    in_valid = 1'b0;
    in_sym = '0;
    cfg_load = 1'b0;
    cfg_pattern = '0;
    cfg_overlap = 1'b0;
    cfg_trap_en = 1'b0;
    cfg_trap_sym = '0;
    clear = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_output("reset_idle", int'(o_idle), 1);
    check_output("reset_state", int'(state_o), 0);
    rst = 1'b1;
    chk_en = 1'b1;

    $display("[TB] basic match");
    load_cfg(6'b00_10_01, 1'b0, 1'b0, 2'b00);
    feed(2'b01);
    check_output("t1_acc1", int'(state_o), 1);
    feed(2'b10);
    check_output("t1_acc2", int'(state_o), 1);
    feed(2'b00);
    check_output("t1_hit", int'(o_match), 1);
    check_output("t1_cnt", int'(match_cnt), 1);
    apply_stimulus(1'b0, '0, 1'b0, 1'b0);
    check_output("t1_back_idle", int'(state_o), 0);

    $display("[TB] overlap on/off");
    load_cfg(6'b01_01_01, 1'b1, 1'b0, 2'b00);
    repeat (5) feed(2'b01);
    check_output("t2_ov_cnt", int'(match_cnt), 3);
    check_output("t2_ov_state", int'(state_o), 2);
    load_cfg(6'b01_01_01, 1'b0, 1'b0, 2'b00);
    repeat (5) feed(2'b01);
    check_output("t2_nov_cnt", int'(match_cnt), 1);
    check_output("t2_nov_state", int'(state_o), 1);

    $display("[TB] trap then clear");
    load_cfg(6'b00_10_01, 1'b0, 1'b1, 2'b11);
    feed(2'b01);
    feed(2'b11);
    check_output("t3_trap", int'(o_trap), 1);
    feed(2'b10);
    feed(2'b00);
    check_output("t3_trap_held", int'(state_o), 3);
    check_output("t3_trap_cnt", int'(match_cnt), 0);
    apply_stimulus(1'b0, '0, 1'b0, 1'b1);
    check_output("t3_clear_idle", int'(o_idle), 1);
    feed(2'b01);
    feed(2'b10);
    feed(2'b00);
    check_output("t3_rematch", int'(match_cnt), 1);

    $display("[TB] gapped symbols");
    load_cfg(6'b00_10_01, 1'b0, 1'b0, 2'b00);
    for (int i = 0; i < 3; i++) begin
      s = (i == 0) ? 2'b01 : (i == 1) ? 2'b10 : 2'b00;
      feed(s);
      repeat (2) apply_stimulus(1'b0, SYM_W'($urandom), 1'b0, 1'b0);
    end
    check_output("t4_cnt", int'(match_cnt), 1);

    $display("[TB] async reset mid sequence");
    load_cfg(6'b00_10_01, 1'b0, 1'b0, 2'b00);
    feed(2'b01);
    feed(2'b10);
    #2 rst = 1'b0;
    model_reset();
    #1;
    check_output("t5_async_idle", int'(o_idle), 1);
    check_output("t5_async_cnt", int'(match_cnt), 0);
    @(negedge clk);
    rst = 1'b1;
    feed(2'b10);
    feed(2'b00);
    check_output("t5_no_match", int'(match_cnt), 0);
    check_output("t5_acc", int'(state_o), 1);

    $display("[TB] counter saturation");
    load_cfg(6'b00_10_01, 1'b0, 1'b0, 2'b00);
    repeat (5) begin
      feed(2'b01);
      feed(2'b10);
      feed(2'b00);
    end
    check_output("t6_sat", int'(match_cnt), 3);
    load_cfg(6'b00_10_01, 1'b0, 1'b0, 2'b00);
    check_output("t6_load_zero", int'(match_cnt), 0);

    $display("[TB] random traffic");
    load_cfg(HW'($urandom), 1'b1, 1'b0, 2'b00);
    for (int i = 0; i < 4000; i++) begin
      r = int'($urandom_range(0, 199));
      if (r < 2) begin
        cfg_pattern = HW'($urandom);
        cfg_overlap = 1'($urandom);
        cfg_trap_en = ($urandom_range(0, 2) == 0);
        cfg_trap_sym = SYM_W'($urandom);
        apply_stimulus(1'($urandom), SYM_W'($urandom), 1'b1, 1'($urandom));
      end else if (r < 4) begin
        apply_stimulus(1'($urandom), SYM_W'($urandom), 1'b0, 1'b1);
      end else begin
        if ($urandom_range(0, 1) == 0)
          s = m_pat[$urandom_range(0, DEPTH-1)*SYM_W +: SYM_W];
        else
          s = SYM_W'($urandom);
        apply_stimulus($urandom_range(0, 9) < 7, s, 1'b0, 1'b0);
      end
    end

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
